// File: rtl/rv_pkg.sv
// Shared definitions for the miniRV writeback path.
//   N_REGS   : number of architectural registers (x0 reads as zero)
//   REG_ID_W : width of register index fields
//   XLEN     : data word width
//   wb_req_t : one writeback request (valid, destination, data)
//   wb_src_e : writeback source identifiers, value doubles as grant bit index
//   rd_in_range : true for a destination that may actually be written
package rv_pkg;

    localparam int N_REGS   = 16;
    localparam int REG_ID_W = 5;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic                valid;
        logic [REG_ID_W-1:0] rd;
        logic [XLEN-1:0]     data;
    } wb_req_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    // x0 is hardwired and indices past the register file are discarded.
    function automatic logic rd_in_range(input logic [REG_ID_W-1:0] rd);
        return (rd != '0) && (32'(rd) < N_REGS);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clock, reset : system clock, synchronous active-high reset
//   req[1:0]     : request lines, bit index = wb_src_e value
//   grant[1:0]   : one-hot combinational grant (all zero when idle)
// The last-grant pointer only moves when both requesters compete, so a
// lone requester never steals the next turn from the other one.
module rr_arb2
    import rv_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    wb_src_e last_grant_reg;
    wb_src_e last_grant_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_reg <= WB_ALU;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        grant           = 2'b00;
        last_grant_next = last_grant_reg;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                // Contended: the side that did not win last time goes now.
                if (last_grant_reg == WB_ALU) begin
                    grant           = 2'b10;
                    last_grant_next = WB_LSU;
                end else begin
                    grant           = 2'b01;
                    last_grant_next = WB_ALU;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
//   clock, reset            : system clock, synchronous active-high reset
//   claim_valid/claim_rd    : issue reserves a destination register
//   chk_rs1/chk_rs2, hazard : decode hazard lookup against the scoreboard
//   alu_* / lsu_*           : writeback requests, ready = accepted this cycle
//   rf_wen/rf_rd/rf_wdata   : registered register-file write port
//   pending                 : scoreboard bit vector (bit 0 always 0)
//   err_unclaimed           : sticky flag, a write hit a non-pending register
// The scoreboard bit clears on the same edge the output register loads, so
// the RF only holds the data one cycle after the bit drops; decode must not
// rely on a bypass from this block.
module rf_wb_arbiter
    import rv_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                claim_valid,
    input  logic [REG_ID_W-1:0] claim_rd,
    input  logic [REG_ID_W-1:0] chk_rs1,
    input  logic [REG_ID_W-1:0] chk_rs2,
    output logic                hazard,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_ID_W-1:0] alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [REG_ID_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]     lsu_data,
    output logic                rf_wen,
    output logic [REG_ID_W-1:0] rf_rd,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [N_REGS-1:0]   pending,
    output logic                err_unclaimed
);

    wb_req_t             alu_req;
    wb_req_t             lsu_req;
    wb_req_t             win_req;
    logic [1:0]          grant;

    logic [N_REGS-1:0]   claim_mask;
    logic [N_REGS-1:0]   win_mask;
    logic [N_REGS-1:0]   rs1_hit;
    logic [N_REGS-1:0]   rs2_hit;
    logic [N_REGS-1:0]   claim_hit;

    logic [N_REGS-1:0]   pending_reg;
    logic [N_REGS-1:0]   pending_next;
    logic                err_reg;
    logic                err_next;
    logic                rf_wen_reg;
    logic [REG_ID_W-1:0] rf_rd_reg;
    logic [XLEN-1:0]     rf_wdata_reg;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({lsu_req.valid, alu_req.valid}),
        .grant (grant)
    );

    assign alu_ready = grant[WB_ALU];
    assign lsu_ready = grant[WB_LSU];

    // Winner mux; valid here means "something was accepted this cycle".
    always_comb begin
        win_req       = grant[WB_LSU] ? lsu_req : alu_req;
        win_req.valid = |grant;
    end

    // Per-register decodes. Bit 0 is never matched, and indices at or above
    // N_REGS have no bit at all, so out-of-range ids fall out naturally.
    assign claim_mask[0] = 1'b0;
    assign win_mask[0]   = 1'b0;
    assign rs1_hit[0]    = 1'b0;
    assign rs2_hit[0]    = 1'b0;
    assign claim_hit[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < N_REGS; gi++) begin : g_reg
            assign claim_mask[gi] = claim_valid   && (claim_rd   == REG_ID_W'(gi));
            assign win_mask[gi]   = win_req.valid && (win_req.rd == REG_ID_W'(gi));
            assign rs1_hit[gi]    = pending_reg[gi] && (chk_rs1  == REG_ID_W'(gi));
            assign rs2_hit[gi]    = pending_reg[gi] && (chk_rs2  == REG_ID_W'(gi));
            assign claim_hit[gi]  = pending_reg[gi] && (claim_rd == REG_ID_W'(gi));
        end
    endgenerate

    // Clear first, then set: a same-cycle claim of the register being
    // written back keeps the bit pending for the new producer.
    assign pending_next = (pending_reg & ~win_mask) | claim_mask;
    assign err_next     = err_reg | (|(win_mask & ~pending_reg));

    assign hazard = (|rs1_hit) | (|rs2_hit) | (claim_valid & (|claim_hit));

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_reg  <= '0;
            err_reg      <= 1'b0;
            rf_wen_reg   <= 1'b0;
            rf_rd_reg    <= '0;
            rf_wdata_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            err_reg     <= err_next;
            // Invalid destinations are consumed but never reach the RF.
            rf_wen_reg  <= win_req.valid && rd_in_range(win_req.rd);
            if (win_req.valid) begin
                rf_rd_reg    <= win_req.rd;
                rf_wdata_reg <= win_req.data;
            end
        end
    end

    assign rf_wen        = rf_wen_reg;
    assign rf_rd         = rf_rd_reg;
    assign rf_wdata      = rf_wdata_reg;
    assign pending       = pending_reg;
    assign err_unclaimed = err_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter. Expected RF writes are queued as
// stimulus is driven and popped by a monitor whenever rf_wen is seen.
module tb_rf_wb_arbiter;
    import rv_pkg::*;

    logic                clock;
    logic                reset;
    logic                claim_valid;
    logic [REG_ID_W-1:0] claim_rd;
    logic [REG_ID_W-1:0] chk_rs1;
    logic [REG_ID_W-1:0] chk_rs2;
    logic                hazard;
    logic                alu_valid;
    logic                alu_ready;
    logic [REG_ID_W-1:0] alu_rd;
    logic [XLEN-1:0]     alu_data;
    logic                lsu_valid;
    logic                lsu_ready;
    logic [REG_ID_W-1:0] lsu_rd;
    logic [XLEN-1:0]     lsu_data;
    logic                rf_wen;
    logic [REG_ID_W-1:0] rf_rd;
    logic [XLEN-1:0]     rf_wdata;
    logic [N_REGS-1:0]   pending;
    logic                err_unclaimed;

    typedef struct {
        logic [REG_ID_W-1:0] rd;
        logic [XLEN-1:0]     data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    rf_wb_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .claim_valid   (claim_valid),
        .claim_rd      (claim_rd),
        .chk_rs1       (chk_rs1),
        .chk_rs2       (chk_rs2),
        .hazard        (hazard),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .rf_wen        (rf_wen),
        .rf_rd         (rf_rd),
        .rf_wdata      (rf_wdata),
        .pending       (pending),
        .err_unclaimed (err_unclaimed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next active edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic claim(input logic [REG_ID_W-1:0] rd);
        claim_valid = 1'b1;
        claim_rd    = rd;
        step();
        claim_valid = 1'b0;
    endtask

    task automatic push(input logic [REG_ID_W-1:0] rd, input logic [XLEN-1:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Write monitor: every observed RF write must match the queue head.
    always @(negedge clock) begin
        if (rf_wen === 1'b1) begin
            $display("rf write rd=%0d data=%08h", rf_rd, rf_wdata);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(rf_rd), 64'hFFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wb_rd", 64'(rf_rd), 64'(w.rd));
                check("wb_data", 64'(rf_wdata), 64'(w.data));
            end
        end
    end

    logic [REG_ID_W-1:0] alt_alu_rd [3];
    logic [REG_ID_W-1:0] alt_lsu_rd [4];

    initial begin
        int ai;
        int li;
        logic exp_lsu;

        reset = 1'b1;
        claim_valid = 1'b0; claim_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        repeat (3) step();
        check("rst_wen", 64'(rf_wen), 64'd0);
        check("rst_rd", 64'(rf_rd), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_err", 64'(err_unclaimed), 64'd0);
        reset = 1'b0;
        step();

        // Single write to x5
        claim(5'd5);
        check("t1_pend_set", 64'(pending[5]), 64'd1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("t1_alu_ready", 64'(alu_ready), 64'd1);
        check("t1_lsu_ready", 64'(lsu_ready), 64'd0);
        push(5'd5, 32'hDEADBEEF);
        step();
        alu_valid = 1'b0;
        check("t1_wen", 64'(rf_wen), 64'd1);
        check("t1_pend_clr", 64'(pending[5]), 64'd0);
        step();
        check("t1_wen_pulse", 64'(rf_wen), 64'd0);
        check("t1_rd_hold", 64'(rf_rd), 64'd5);

        // Contention: first tie after reset goes to LSU
        claim(5'd3);
        claim(5'd4);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        #1;
        check("t2_c1_lsu_ready", 64'(lsu_ready), 64'd1);
        check("t2_c1_alu_ready", 64'(alu_ready), 64'd0);
        push(5'd4, 32'h22);
        step();
        lsu_rd = 5'd0; lsu_data = 32'h33;
        #1;
        check("t2_c2_alu_ready", 64'(alu_ready), 64'd1);
        check("t2_c2_lsu_ready", 64'(lsu_ready), 64'd0);
        push(5'd3, 32'h11);
        step();
        alu_valid = 1'b0;
        #1;
        check("t2_c3_lsu_ready", 64'(lsu_ready), 64'd1);
        step();
        lsu_valid = 1'b0;
        check("t2_pending", 64'(pending), 64'd0);
        check("t2_err", 64'(err_unclaimed), 64'd0);

        // Alternation over six accepted writes
        alt_alu_rd[0] = 5'd10; alt_alu_rd[1] = 5'd11; alt_alu_rd[2] = 5'd12;
        alt_lsu_rd[0] = 5'd13; alt_lsu_rd[1] = 5'd14; alt_lsu_rd[2] = 5'd15; alt_lsu_rd[3] = 5'd0;
        for (int k = 10; k <= 15; k++) claim(REG_ID_W'(k));
        ai = 0;
        li = 0;
        for (int k = 0; k < 6; k++) begin
            alu_valid = (ai < 3);
            lsu_valid = (li < 4);
            alu_rd    = alt_alu_rd[ai < 3 ? ai : 2];
            alu_data  = 32'hA000_0000 + 32'(ai);
            lsu_rd    = alt_lsu_rd[li];
            lsu_data  = 32'hB000_0000 + 32'(li);
            #1;
            exp_lsu = (k % 2 == 0);
            check("t3_lsu_ready", 64'(lsu_ready), 64'(exp_lsu));
            check("t3_alu_ready", 64'(alu_ready), 64'(!exp_lsu));
            if (exp_lsu) begin
                if (lsu_rd != 5'd0) push(lsu_rd, lsu_data);
                li++;
            end else begin
                push(alu_rd, alu_data);
                ai++;
            end
            step();
        end
        alu_valid = 1'b0;
        lsu_rd = alt_lsu_rd[3];
        #1;
        check("t3_tail_lsu_ready", 64'(lsu_ready), 64'd1);
        step();
        lsu_valid = 1'b0;
        check("t3_pending", 64'(pending), 64'd0);

        // Hazard lookup
        claim(5'd7);
        chk_rs1 = 5'd7;
        #1;
        check("t4_haz_rs1", 64'(hazard), 64'd1);
        chk_rs1 = 5'd0;
        #1;
        check("t4_haz_x0", 64'(hazard), 64'd0);
        chk_rs1 = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777;
        #1;
        check("t4_haz_before_wb", 64'(hazard), 64'd1);
        push(5'd7, 32'h7777);
        step();
        lsu_valid = 1'b0;
        check("t4_haz_after_wb", 64'(hazard), 64'd0);
        chk_rs1 = 5'd0;
        claim(5'd8);
        chk_rs2 = 5'd8;
        #1;
        check("t4_haz_rs2", 64'(hazard), 64'd1);
        chk_rs2 = 5'd0;
        claim_valid = 1'b1; claim_rd = 5'd8;
        #1;
        check("t4_haz_waw", 64'(hazard), 64'd1);
        claim_rd = 5'd20;
        #1;
        check("t4_haz_oob", 64'(hazard), 64'd0);
        claim_valid = 1'b0;

        // Same-cycle claim and clear of x9
        claim(5'd9);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        claim_valid = 1'b1; claim_rd = 5'd9;
        push(5'd9, 32'h99);
        step();
        alu_valid = 1'b0; claim_valid = 1'b0;
        check("t5_pend9", 64'(pending[9]), 64'd1);
        check("t5_wen", 64'(rf_wen), 64'd1);
        check("t5_err", 64'(err_unclaimed), 64'd0);

        // Invalid destinations are accepted and dropped
        step();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        #1;
        check("t6_x0_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        check("t6_x0_wen", 64'(rf_wen), 64'd0);
        check("t6_x0_err", 64'(err_unclaimed), 64'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h2020;
        #1;
        check("t6_oob_ready", 64'(lsu_ready), 64'd1);
        step();
        lsu_valid = 1'b0;
        check("t6_oob_wen", 64'(rf_wen), 64'd0);
        check("t6_oob_err", 64'(err_unclaimed), 64'd0);

        // Unclaimed write sets the sticky error
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        push(5'd6, 32'h66);
        step();
        alu_valid = 1'b0;
        check("t7_wen", 64'(rf_wen), 64'd1);
        check("t7_err", 64'(err_unclaimed), 64'd1);
        step();
        check("t7_err_sticky", 64'(err_unclaimed), 64'd1);

        // Reset coinciding with an accepted write
        claim(5'd2);
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222;
        reset = 1'b1;
        step();
        alu_valid = 1'b0;
        check("t8_wen", 64'(rf_wen), 64'd0);
        check("t8_pending", 64'(pending), 64'd0);
        check("t8_err", 64'(err_unclaimed), 64'd0);
        reset = 1'b0;
        step();
        check("t8_wen_after", 64'(rf_wen), 64'd0);

        step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
